// File: rtl/rgb_switch_conditioner_pkg.sv
// -----------------------------------------------------------------------------
// Package: rgb_cond_pkg
// Purpose: shared constants and types for the RGB switch conditioner.
//   NUM_CH            number of colour channels
//   CH_R/CH_G/CH_B    bit positions of red/green/blue in the channel vectors
//   debounce_state_t  2-bit state of the per-channel debounce FSM
//   vs_active()       maps the raw v_sync level onto "inside the sync pulse"
// -----------------------------------------------------------------------------
package rgb_cond_pkg;

    localparam int NUM_CH = 3;
    localparam int CH_R   = 2;
    localparam int CH_G   = 1;
    localparam int CH_B   = 0;

    // Encoding chosen so that bit 1 is the debounced level (S_HI, S_WAIT_LO).
    typedef enum logic [1:0] {
        S_LO      = 2'd0,
        S_WAIT_HI = 2'd1,
        S_HI      = 2'd2,
        S_WAIT_LO = 2'd3
    } debounce_state_t;

    // True while v_sync sits inside its pulse, whatever the pulse polarity.
    function automatic logic vs_active(input logic v_sync, input logic active_low);
        return active_low ? ~v_sync : v_sync;
    endfunction

endpackage

// File: rtl/rgb_switch_conditioner_debounce_channel.sv
// -----------------------------------------------------------------------------
// Module: debounce_channel
// Purpose: one colour switch: two-flop synchroniser followed by a debounce FSM
//          that only accepts a new level after DEBOUNCE_CYCLES stable samples.
// Ports:
//   clk    in   system clock
//   reset  in   synchronous, active-low reset
//   raw    in   raw asynchronous switch level
//   db     out  debounced level (state register bit, no combinational path)
//   rise   out  high in the cycle whose clock edge moves the FSM S_WAIT_HI->S_HI
// -----------------------------------------------------------------------------
module debounce_channel
    import rgb_cond_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int CNT_W           = 20
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic db,
    output logic rise
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [1:0]       r_sync;
    debounce_state_t  r_state;
    logic [CNT_W-1:0] r_cnt;
    debounce_state_t  w_state_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_s;

    assign w_s = r_sync[1];

    // State register: synchroniser, FSM state and stability counter.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_sync  <= 2'b00;
            r_state <= S_LO;
            r_cnt   <= CNT_ZERO;
        end else begin
            r_sync  <= {r_sync[0], raw};
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next-state logic; the counter is cleared whenever the FSM changes state,
    // so it saturates at CNT_LAST and never wraps.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            S_LO: begin
                if (w_s) begin
                    w_state_nxt = S_WAIT_HI;
                    w_cnt_nxt   = CNT_ZERO;
                end else begin
                    w_state_nxt = S_LO;
                end
            end
            S_WAIT_HI: begin
                if (!w_s) begin
                    w_state_nxt = S_LO;
                    w_cnt_nxt   = CNT_ZERO;
                end else if (r_cnt == CNT_LAST) begin
                    w_state_nxt = S_HI;
                    w_cnt_nxt   = CNT_ZERO;
                end else begin
                    w_cnt_nxt   = r_cnt + CNT_ONE;
                end
            end
            S_HI: begin
                if (!w_s) begin
                    w_state_nxt = S_WAIT_LO;
                    w_cnt_nxt   = CNT_ZERO;
                end else begin
                    w_state_nxt = S_HI;
                end
            end
            S_WAIT_LO: begin
                if (w_s) begin
                    w_state_nxt = S_HI;
                    w_cnt_nxt   = CNT_ZERO;
                end else if (r_cnt == CNT_LAST) begin
                    w_state_nxt = S_LO;
                    w_cnt_nxt   = CNT_ZERO;
                end else begin
                    w_cnt_nxt   = r_cnt + CNT_ONE;
                end
            end
            default: begin
                w_state_nxt = S_LO;
                w_cnt_nxt   = CNT_ZERO;
            end
        endcase
    end

    // Output decode: db is a pure state decode, rise flags the committing edge.
    always_comb begin
        db   = (r_state == S_HI) || (r_state == S_WAIT_LO);
        rise = (r_state == S_WAIT_HI) && w_s && (r_cnt == CNT_LAST);
    end

endmodule

// File: rtl/rgb_switch_conditioner.sv
// -----------------------------------------------------------------------------
// Module: rgb_switch_conditioner
// Purpose: conditions three raw colour switches into frame-stable red/green/blue
//          levels for the VGA top. Each switch is synchronised and debounced;
//          the selected levels are latched only on entry into the v_sync pulse,
//          so the colour never changes mid-frame.
// Ports:
//   clk         in   system clock (same as VGA)
//   reset       in   synchronous, active-low reset
//   sw_raw[2:0] in   raw switches, bit2=red, bit1=green, bit0=blue
//   v_sync      in   vertical sync (same net as VGA.v_sync)
//   red/green/blue out frame-stable colour levels
//   frame_tick  out  one-cycle strobe on the cycle the colour outputs update
// Configuration macro: RGB_TOGGLE_MODE_EN
//   defined   -> every debounced press flips that channel's colour
//   undefined -> the colour follows the debounced switch level
// -----------------------------------------------------------------------------
module rgb_switch_conditioner
    import rgb_cond_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES  = 1_000_000,
    parameter int CNT_W            = 20,
    parameter int VSYNC_ACTIVE_LOW = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] sw_raw,
    input  logic       v_sync,
    output logic       red,
    output logic       green,
    output logic       blue,
    output logic       frame_tick
);

    logic [NUM_CH-1:0] w_db;
    logic [NUM_CH-1:0] w_rise;
    logic [NUM_CH-1:0] w_sel_src;
    logic [NUM_CH-1:0] r_sel;
    logic [NUM_CH-1:0] r_rgb;
    logic              r_tick;
    logic              r_vs_act_d;
    logic              w_vs_act;
    logic              w_frame_edge;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        debounce_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W)
        ) u_ch (
            .clk   (clk),
            .reset (reset),
            .raw   (sw_raw[g]),
            .db    (w_db[g]),
            .rise  (w_rise[g])
        );
    end

    assign w_vs_act     = vs_active(v_sync, VSYNC_ACTIVE_LOW != 0);
    // Only the entry into the pulse counts; a held pulse gives one edge.
    assign w_frame_edge = w_vs_act & ~r_vs_act_d;

`ifdef RGB_TOGGLE_MODE_EN
    logic [NUM_CH-1:0] r_toggle;

    // Toggle register: each debounced press flips its own channel.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_toggle <= {NUM_CH{1'b0}};
        end else begin
            r_toggle <= r_toggle ^ w_rise;
        end
    end

    assign w_sel_src = r_toggle;
`else
    logic w_unused_rise;

    assign w_unused_rise = ^w_rise;
    assign w_sel_src     = w_db;
`endif

    // Selection register: one cycle of delay so a commit coinciding with the
    // frame edge is only seen on the following frame.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_sel <= {NUM_CH{1'b0}};
        end else begin
            r_sel <= w_sel_src;
        end
    end

    // Frame latch: vsync history, colour outputs and the update strobe.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_vs_act_d <= 1'b0;
            r_rgb      <= {NUM_CH{1'b0}};
            r_tick     <= 1'b0;
        end else begin
            r_vs_act_d <= w_vs_act;
            if (w_frame_edge) begin
                r_rgb  <= r_sel;
                r_tick <= 1'b1;
            end else begin
                r_tick <= 1'b0;
            end
        end
    end

    assign red        = r_rgb[CH_R];
    assign green      = r_rgb[CH_G];
    assign blue       = r_rgb[CH_B];
    assign frame_tick = r_tick;

endmodule

// File: tb/tb_rgb_switch_conditioner.sv
// -----------------------------------------------------------------------------
// Testbench for rgb_switch_conditioner (DEBOUNCE_CYCLES=4, CNT_W=3, active-low
// v_sync). A reference model predicts the colour latched at every frame edge
// and queues it; a monitor pops one entry per frame_tick and compares.
// -----------------------------------------------------------------------------
module tb_rgb_switch_conditioner;
    import rgb_cond_pkg::*;

    localparam int N = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] sw_raw;
    logic       v_sync;
    logic       red, green, blue, frame_tick;

    int vectors     = 0;
    int miscompares = 0;
    int tick_cnt    = 0;

    logic [2:0] exp_q[$];
    logic [2:0] last_rgb = 3'b000;

    always #5 clk = ~clk;

    rgb_switch_conditioner #(
        .DEBOUNCE_CYCLES  (N),
        .CNT_W            (3),
        .VSYNC_ACTIVE_LOW (1)
    ) dut (
        .clk        (clk),
        .reset      (rst_n),
        .sw_raw     (sw_raw),
        .v_sync     (v_sync),
        .red        (red),
        .green      (green),
        .blue       (blue),
        .frame_tick (frame_tick)
    );

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a switch's accepted level flips once the synchronised
    // input has disagreed with it for N+1 consecutive samples.
    logic [2:0] m_d1, m_d2, m_db, m_sel, m_tog;
    int         m_run[3];
    logic       m_vsd;

    always @(posedge clk) begin : ref_model
        logic [2:0] s;
        logic [2:0] rise;
        logic       vs;
        if (!rst_n) begin
            m_d1 = 3'b000; m_d2 = 3'b000; m_db = 3'b000;
            m_sel = 3'b000; m_tog = 3'b000; m_vsd = 1'b0;
            for (int i = 0; i < 3; i++) m_run[i] = 0;
            exp_q.delete();
        end else begin
            vs = ~v_sync;
            if (vs && !m_vsd) exp_q.push_back(m_sel);
            m_vsd = vs;
`ifdef RGB_TOGGLE_MODE_EN
            m_sel = m_tog;
`else
            m_sel = m_db;
`endif
            s    = m_d2;
            m_d2 = m_d1;
            m_d1 = sw_raw;
            rise = 3'b000;
            for (int i = 0; i < 3; i++) begin
                if (s[i] != m_db[i]) begin
                    m_run[i]++;
                    if (m_run[i] == N + 1) begin
                        m_db[i]  = ~m_db[i];
                        m_run[i] = 0;
                        rise[i]  = m_db[i];
                    end
                end else begin
                    m_run[i] = 0;
                end
            end
            m_tog = m_tog ^ rise;
        end
    end

    // Monitor: checks reset state, each frame update and holding in between.
    always @(posedge clk) begin : monitor
        logic [2:0] e;
        #1;
        if (!rst_n) begin
            chk("reset_state", {red, green, blue, frame_tick}, 0);
            last_rgb = 3'b000;
        end else if (frame_tick) begin
            tick_cnt++;
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_tick: got tick with rgb=%b, required no tick", {red, green, blue});
            end else begin
                e = exp_q.pop_front();
                chk("frame_latch", {red, green, blue}, e);
                last_rgb = e;
            end
        end else begin
            chk("missing_tick", exp_q.size(), 0);
            chk("hold", {red, green, blue}, last_rgb);
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic frame(input int lo);
        v_sync = 1'b0;
        cyc(lo);
        v_sync = 1'b1;
    endtask

    initial begin
        int t0;
        int vcnt;
        rst_n  = 1'b0;
        sw_raw = 3'b111;
        v_sync = 1'b1;

        // Reset with switches on and v_sync toggling
        repeat (4) begin
            @(negedge clk);
            v_sync = ~v_sync;
        end
        chk("reset_rgb", {red, green, blue, frame_tick}, 0);
        rst_n  = 1'b1;
        sw_raw = 3'b000;
        cyc(10);

        // Clean red press
        sw_raw = 3'b100;
        cyc(10);
        frame(4);
        cyc(2);
        chk("clean_press", {red, green, blue}, 3'b100);

        // Green glitch of 3 cycles
        sw_raw[1] = 1'b1;
        cyc(3);
        sw_raw[1] = 1'b0;
        cyc(10);
        frame(3);
        cyc(20);
        frame(3);
        cyc(2);
        chk("glitch_green", green, 0);

        // Blue commit coincides with the frame edge
        sw_raw[0] = 1'b1;
        cyc(7);
        frame(3);
        chk("coincide_old", blue, 0);
        cyc(20);
        frame(3);
        cyc(1);
        chk("coincide_next", blue, 1);

        // Held v_sync with red released mid-pulse
        t0 = tick_cnt;
        v_sync = 1'b0;
        cyc(30);
        sw_raw[2] = 1'b0;
        cyc(70);
        v_sync = 1'b1;
        cyc(2);
        chk("held_vsync_ticks", tick_cnt - t0, 1);
        chk("held_vsync_hold", red, 1);
        cyc(20);
        frame(3);
        cyc(1);
`ifdef RGB_TOGGLE_MODE_EN
        chk("after_release", red, 1);
`else
        chk("after_release", red, 0);
`endif

        // Second red press, release, third press
        sw_raw[2] = 1'b1;
        cyc(12);
        frame(3);
        cyc(1);
`ifdef RGB_TOGGLE_MODE_EN
        chk("second_press", red, 0);
`else
        chk("second_press", red, 1);
`endif
        sw_raw[2] = 1'b0;
        cyc(12);
        frame(3);
        cyc(1);
        chk("second_release", red, 0);
        sw_raw[2] = 1'b1;
        cyc(12);
        frame(3);
        cyc(1);
        chk("third_press", red, 1);

        // Reset mid-count on green discards the partial count
        sw_raw[1] = 1'b1;
        cyc(5);
        rst_n = 1'b0;
        cyc(1);
        rst_n = 1'b1;
        cyc(5);
        frame(2);
        cyc(1);
        chk("midcount_discard", green, 0);
        cyc(10);
        frame(2);
        cyc(1);
        chk("midcount_full", green, 1);

        // Randomised switches and frame timing
        vcnt = 20;
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            if ($urandom_range(0, 24) == 0) begin
                sw_raw[$urandom_range(0, 2)] ^= 1'b1;
            end
            if (vcnt == 0) begin
                if (v_sync) begin
                    v_sync = 1'b0;
                    vcnt   = int'($urandom_range(1, 6));
                end else begin
                    v_sync = 1'b1;
                    vcnt   = int'($urandom_range(8, 60));
                end
            end else begin
                vcnt--;
            end
        end

        v_sync = 1'b1;
        cyc(10);
        chk("queue_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
